// File: rtl/restoring_divider_if.sv
// Switch/button inputs and hex-display outputs of the restoring divider.
// The master drives the synchronized controls; the slave is the divider itself.
interface restoring_divider_if #(parameter int WIDTH = 8);
  logic             LoadB;
  logic             Execute;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic [WIDTH-1:0] Dval;
  logic             Busy;
  logic             Done;
  logic             DivZero;

  modport master (
    output LoadB, Execute, Din,
    input  Aval, Bval, Dval, Busy, Done, DivZero
  );

  modport slave (
    input  LoadB, Execute, Din,
    output Aval, Bval, Dval, Busy, Done, DivZero
  );
endinterface

// File: rtl/restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock; quotient on Bval, remainder on Aval.
// Define SIGNED_DIV_EN for two's-complement operands (adds a sign-fix cycle after iterating).
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  restoring_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SIGNED_DIV_EN
  typedef enum logic [1:0] {IDLE, ITER, DONE, FIX} state_e;
`else
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;

  logic [2*WIDTH-1:0] shifted;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   dmag;
  logic [WIDTH-1:0]   din_mag;

`ifdef SIGNED_DIV_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  // Iteration always works on magnitudes; signs are reapplied in FIX.
  assign dmag    = d_q[WIDTH-1]     ? (~d_q + WIDTH'(1))     : d_q;
  assign din_mag = bus.Din[WIDTH-1] ? (~bus.Din + WIDTH'(1)) : bus.Din;
`else
  assign dmag    = d_q;
  assign din_mag = bus.Din;
`endif

  assign shifted = {a_q, b_q} << 1;
  assign trial   = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, dmag};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
`ifdef SIGNED_DIV_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.Execute) begin
          a_d   = '0;
          b_d   = din_mag;
          cnt_d = '0;
          dz_d  = 1'b0;
`ifdef SIGNED_DIV_EN
          qneg_d = bus.Din[WIDTH-1] ^ d_q[WIDTH-1];
          rneg_d = bus.Din[WIDTH-1];
`endif
          if (d_q == '0) begin
            b_d     = '1;
            a_d     = bus.Din;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = ITER;
          end
        end else if (bus.LoadB) begin
          d_d = bus.Din;
        end
      end
      ITER: begin
        // Restore (keep the shifted partial remainder) when the trial subtract borrows.
        if (trial[WIDTH]) begin
          a_d = shifted[2*WIDTH-1:WIDTH];
          b_d = {shifted[WIDTH-1:1], 1'b0};
        end else begin
          a_d = trial[WIDTH-1:0];
          b_d = {shifted[WIDTH-1:1], 1'b1};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
`ifdef SIGNED_DIV_EN
          state_d = FIX;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef SIGNED_DIV_EN
      FIX: begin
        if (qneg_q) b_d = ~b_q + WIDTH'(1);
        if (rneg_q) a_d = ~a_q + WIDTH'(1);
        state_d = DONE;
      end
`endif
      DONE: begin
        // Wait for the button to be released so one press gives one division.
        if (!bus.Execute) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
`ifdef SIGNED_DIV_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
`ifdef SIGNED_DIV_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign bus.Aval    = a_q;
  assign bus.Bval    = b_q;
  assign bus.Dval    = d_q;
  assign bus.Busy    = (state_q == ITER);
  assign bus.Done    = (state_q == DONE);
  assign bus.DivZero = dz_q;
endmodule

// File: tb/tb_restoring_divider.sv
// Directed-vector bench for restoring_divider; expectations follow SIGNED_DIV_EN when defined.
module tb_restoring_divider;
  logic Clk, Reset;
  int   total = 0;
  int   bad   = 0;
  int   lat;
  int   busy_cnt;

`ifdef SIGNED_DIV_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 9;
`endif

  restoring_divider_if #(.WIDTH(8)) bus ();
  restoring_divider #(.WIDTH(8)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Extra leading tick lets a preceding DONE fall back to IDLE before LoadB is sampled.
  task automatic load_b(input logic [7:0] v);
    tick();
    bus.LoadB = 1'b1;
    bus.Din   = v;
    tick();
    bus.LoadB = 1'b0;
  endtask

  task automatic do_exec(input logic [7:0] v, output int n);
    bus.Execute = 1'b1;
    bus.Din     = v;
    tick();
    bus.Execute = 1'b0;
    bus.LoadB   = 1'b0;
    n = 1;
    while (!bus.Done && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    Reset       = 1'b1;
    bus.LoadB   = 1'b0;
    bus.Execute = 1'b0;
    bus.Din     = '0;
    tick();
    tick();
    chk("rst_aval", bus.Aval, 8'h00);
    chk("rst_bval", bus.Bval, 8'h00);
    chk("rst_dval", bus.Dval, 8'h00);
    chk("rst_flags", {bus.Busy, bus.Done, bus.DivZero}, 3'b000);
    Reset = 1'b0;

    // 100 / 7
    load_b(8'h07);
    chk("ld_dval", bus.Dval, 8'h07);
    bus.Execute = 1'b1;
    bus.Din     = 8'h64;
    tick();
    bus.Execute = 1'b0;
    chk("iter_busy", bus.Busy, 1'b1);
    lat = 1;
    while (!bus.Done && lat < 40) begin
      tick();
      lat++;
    end
    chk("t1_lat", lat, LAT);
    chk("t1_q", bus.Bval, 8'h0E);
    chk("t1_r", bus.Aval, 8'h02);
    chk("t1_dz", bus.DivZero, 1'b0);
    chk("t1_dval", bus.Dval, 8'h07);

    // divide by zero
    load_b(8'h00);
    do_exec(8'h2A, lat);
    chk("dz_lat", lat, 1);
    chk("dz_q", bus.Bval, 8'hFF);
    chk("dz_r", bus.Aval, 8'h2A);
    chk("dz_flag", bus.DivZero, 1'b1);

    // Execute held for 50 clocks: one division only
    load_b(8'h10);
    bus.Execute = 1'b1;
    bus.Din     = 8'hFF;
    busy_cnt    = 0;
    repeat (50) begin
      tick();
      if (bus.Busy) busy_cnt++;
    end
    chk("hold_busy_cnt", busy_cnt, 8);
    chk("hold_done", bus.Done, 1'b1);
`ifdef SIGNED_DIV_EN
    chk("hold_q", bus.Bval, 8'h00);
    chk("hold_r", bus.Aval, 8'hFF);
`else
    chk("hold_q", bus.Bval, 8'h0F);
    chk("hold_r", bus.Aval, 8'h0F);
`endif
    bus.Execute = 1'b0;
    tick();
    chk("rel_done", bus.Done, 1'b0);
    do_exec(8'hFF, lat);
    chk("rep_lat", lat, LAT);
`ifdef SIGNED_DIV_EN
    chk("rep_q", bus.Bval, 8'h00);
    chk("rep_r", bus.Aval, 8'hFF);
`else
    chk("rep_q", bus.Bval, 8'h0F);
    chk("rep_r", bus.Aval, 8'h0F);
`endif

    // LoadB pulsed during ITER is ignored
    load_b(8'h03);
    bus.Execute = 1'b1;
    bus.Din     = 8'h0A;
    tick();
    bus.Execute = 1'b0;
    tick();
    bus.LoadB = 1'b1;
    bus.Din   = 8'h05;
    tick();
    bus.LoadB = 1'b0;
    lat = 3;
    while (!bus.Done && lat < 40) begin
      tick();
      lat++;
    end
    chk("ldi_lat", lat, LAT);
    chk("ldi_q", bus.Bval, 8'h03);
    chk("ldi_r", bus.Aval, 8'h01);
    chk("ldi_dval", bus.Dval, 8'h03);

    // Reset in the 4th ITER cycle
    load_b(8'h07);
    bus.Execute = 1'b1;
    bus.Din     = 8'h64;
    tick();
    bus.Execute = 1'b0;
    repeat (3) tick();
    chk("mid_busy", bus.Busy, 1'b1);
    Reset = 1'b1;
    #1;
    chk("mid_rst_a", bus.Aval, 8'h00);
    chk("mid_rst_b", bus.Bval, 8'h00);
    chk("mid_rst_d", bus.Dval, 8'h00);
    chk("mid_rst_flags", {bus.Busy, bus.Done, bus.DivZero}, 3'b000);
    #2;
    Reset = 1'b0;
    tick();
    tick();
    chk("post_rst_flags", {bus.Busy, bus.Done}, 2'b00);
    chk("post_rst_b", bus.Bval, 8'h00);

    // Execute and LoadB together: Execute wins, divisor unchanged
    load_b(8'h07);
    bus.LoadB = 1'b1;
    do_exec(8'h15, lat);
    chk("pri_lat", lat, LAT);
    chk("pri_dval", bus.Dval, 8'h07);
    chk("pri_q", bus.Bval, 8'h03);
    chk("pri_r", bus.Aval, 8'h00);

    // Signed-oriented vectors (divisor larger than dividend when unsigned)
    load_b(8'hFD);
    do_exec(8'h0A, lat);
    chk("s1_lat", lat, LAT);
`ifdef SIGNED_DIV_EN
    chk("s1_q", bus.Bval, 8'hFD);
    chk("s1_r", bus.Aval, 8'h01);
`else
    chk("s1_q", bus.Bval, 8'h00);
    chk("s1_r", bus.Aval, 8'h0A);
`endif
    load_b(8'hFF);
    do_exec(8'h80, lat);
`ifdef SIGNED_DIV_EN
    chk("s2_q", bus.Bval, 8'h80);
    chk("s2_r", bus.Aval, 8'h00);
`else
    chk("s2_q", bus.Bval, 8'h00);
    chk("s2_r", bus.Aval, 8'h80);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
